fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch sequencer for the 6502 core. It loads the reset vector and reads each opcode and its 0–2 operand bytes from memory. It presents the assembled instruction to the decoder with a level `instruction_ready` handshake, then advances or reloads the program counter when the decoder reports `instruction_done`. It sits between the memory read port and the decoder and is the sole owner of the PC.

## Interface
- `REG_WIDTH`, 8, data/opcode width
- `ADDR_WIDTH`, 16, address/PC width
- `RESET_VECTOR`, 16'hFFFC, address of the reset vector low byte; the high byte is at `RESET_VECTOR+1`

- `clk`  in  1  single clock; all state changes on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `mem_addr`  out  ADDR_WIDTH  read address
- `mem_rd`  out  1  read strobe; data valid on `mem_data` the following cycle
- `mem_data`  in  REG_WIDTH  read data
- `instruction_in`  out  REG_WIDTH  current opcode, to decoder
- `operand`  out  2*REG_WIDTH  {byte2, byte1}; unused bytes are 0
- `address_in`  out  ADDR_WIDTH  address of the current opcode
- `instruction_ready`  out  1  instruction valid, held until done
- `instruction_done`  in  1  decoder finished the current instruction
- `pc_load`  in  1  with done: take `pc_load_addr` as next PC
- `pc_load_addr`  in  ADDR_WIDTH  jump/branch target
- `halt`  in  1  hold before next opcode fetch

## Operation
- **States:** VEC_LO_REQ, VEC_LO_CAP, VEC_HI_REQ, VEC_HI_CAP, OP_REQ, OP_CAP, B1_REQ, B1_CAP, B2_REQ, B2_CAP, ISSUE.
- **Each byte read is a REQ/CAP pair.**
  - REQ drives `mem_rd`=1 and `mem_addr`.
  - CAP registers `mem_data`; `mem_rd`=0 in CAP.
- **Vector load:**
  - VEC_LO_REQ reads `RESET_VECTOR`.
  - VEC_HI_REQ reads `RESET_VECTOR+1`.
  - VEC_HI_CAP loads PC={hi,lo} and goes to OP_REQ.
- **Opcode fetch:**
  - OP_REQ reads PC. If `halt`=1, the FSM stays in OP_REQ with `mem_rd`=0.
  - OP_CAP latches the opcode, `address_in`=PC, `operand`=0, and computes the length `len`.
  - After OP_CAP: `len`=1 → ISSUE; otherwise → B1_REQ.
- **Operand fetch:**
  - B1_REQ reads PC+1; B1_CAP latches `operand[7:0]`. Next: `len`=2 → ISSUE; `len`=3 → B2_REQ.
  - B2_REQ reads PC+2; B2_CAP latches `operand[15:8]`, then → ISSUE.
- **Length rule:** opcode = aaa bbb cc.
  - bbb=001, 101 → 2.
  - bbb=011, 111 → 3.
  - bbb=000:
    - opcode 0x20 → 3;
    - else cc=01 or aaa[2]=1 → 2;
    - else → 1.
  - bbb=010: cc=01 → 2; else → 1.
  - bbb=100: cc=10 → 1; else → 2.
  - bbb=110: cc=01 → 3; else → 1.
- **ISSUE:**
  - `instruction_ready`=1, with opcode, operand and address stable.
  - On `instruction_done`=1: next PC = `pc_load` ? `pc_load_addr` : PC+`len`. Then → OP_REQ with `instruction_ready`=0.
- **Address arithmetic:** all PC and operand address arithmetic is modulo 2^ADDR_WIDTH. PC=0xFFFF with `len`=2 reads operand from 0x0000; next PC=0x0001.
- **Ignored inputs:**
  - `instruction_done` outside ISSUE is ignored.
  - `pc_load` without `instruction_done` is ignored.
  - `halt` is sampled only in OP_REQ. An in-flight fetch or issue completes regardless.
- **Reset:**
  - `reset_n`=0 asynchronously forces state VEC_LO_REQ, PC=0, and every output to 0: `mem_addr`, `mem_rd`, `instruction_in`, `operand`, `address_in`, `instruction_ready`.
  - Asserting reset mid-fetch or mid-issue discards the instruction; on release the sequencer restarts the vector load.

## Timing
- Vector load takes 4 cycles after `reset_n` deasserts.
  - VEC_LO_REQ is the first active cycle after release (first rising edge with `reset_n`=1). `mem_rd` is asserted from that cycle.
- Fetch latency, from OP_REQ to the first ISSUE cycle: 2 cycles for `len`=1, 4 for `len`=2, 6 for `len`=3.
- `instruction_ready` rises on entry to ISSUE and falls on the edge after `instruction_done` is sampled high.
- `instruction_ready` is low for at least 2 cycles (OP_REQ, OP_CAP) between instructions, so every instruction produces a fresh rising edge for the decoder.
- `mem_rd` is never asserted in CAP or ISSUE states. The sequencer issues at most one outstanding read.
- `instruction_in`, `operand` and `address_in` change only in CAP states, never while `instruction_ready`=1.

## Test plan
- **Reset vector:** memory FFFC=0x00, FFFD=0x80 → reads FFFC then FFFD, then first `mem_rd` at 0x8000 on the 5th active cycle.
- **Length decode:**
  - A9 42 (LDA #imm) → ISSUE with `operand`=0x0042, `len`=2.
  - 8D 00 02 (STA abs) → `operand`=0x0200.
  - EA → `len`=1.
  - After done, next opcode fetched at +2, +3, +1 respectively.
- **Handshake:** hold `instruction_done`=0 for 10 cycles → `instruction_ready` stays 1, no `mem_rd`. Pulse done → ready low next cycle, then ≥2 low cycles before the next rise.
- **Jump:** in ISSUE, assert done with `pc_load`=1, `pc_load_addr`=0x1234 → next OP_REQ `mem_addr`=0x1234. A `pc_load` pulse without done → no effect.
- **Wrap and halt:**
  - PC=0xFFFF, opcode A9 → operand read at 0x0000, next PC=0x0001.
  - `halt`=1 in OP_REQ for 5 cycles → no `mem_rd`; fetch resumes the cycle after release.
- **Reset mid-operation:** assert `reset_n`=0 during B1_CAP → all outputs 0 immediately (async). Release → vector reads restart at FFFC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads the reset vector, fetches opcode plus operands, and hands instructions to the decoder
module fetch_sequencer #(
    parameter int REG_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rd,
    input  logic [REG_WIDTH-1:0]   mem_data,
    output logic [REG_WIDTH-1:0]   instruction_in,
    output logic [2*REG_WIDTH-1:0] operand,
    output logic [ADDR_WIDTH-1:0]  address_in,
    output logic                   instruction_ready,
    input  logic                   instruction_done,
    input  logic                   pc_load,
    input  logic [ADDR_WIDTH-1:0]  pc_load_addr,
    input  logic                   halt
);
    typedef enum logic [3:0] {
        VEC_LO_REQ, VEC_LO_CAP, VEC_HI_REQ, VEC_HI_CAP,
        OP_REQ, OP_CAP, B1_REQ, B1_CAP, B2_REQ, B2_CAP, ISSUE
    } state_t;
    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0]  vec_lo;
    logic [1:0]            len;
    function automatic logic [1:0] op_len(input logic [REG_WIDTH-1:0] op);
        logic [2:0] aaa, bbb;
        logic [1:0] cc;
        aaa = op[7:5];
        bbb = op[4:2];
        cc  = op[1:0];
        return bbb[1:0] == 2'b01 ? 2'd2 :
               bbb[1:0] == 2'b11 ? 2'd3 :
               bbb == 3'b000 ? (op == REG_WIDTH'('h20) ? 2'd3 : (cc == 2'b01 || aaa[2]) ? 2'd2 : 2'd1) :
               bbb == 3'b010 ? (cc == 2'b01 ? 2'd2 : 2'd1) :
               bbb == 3'b100 ? (cc == 2'b10 ? 2'd1 : 2'd2) :
               (cc == 2'b01 ? 2'd3 : 2'd1);
    endfunction
    // State register; reset restarts the vector load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= VEC_LO_REQ;
        else          state <= next_state;
    end
    // Next-state logic: REQ/CAP pairs per byte, halt only gates the opcode request
    always_comb begin
        next_state = state;
        case (state)
            VEC_LO_REQ: next_state = VEC_LO_CAP;
            VEC_LO_CAP: next_state = VEC_HI_REQ;
            VEC_HI_REQ: next_state = VEC_HI_CAP;
            VEC_HI_CAP: next_state = OP_REQ;
            OP_REQ:     next_state = halt ? OP_REQ : OP_CAP;
            OP_CAP:     next_state = op_len(mem_data) == 2'd1 ? ISSUE : B1_REQ;
            B1_REQ:     next_state = B1_CAP;
            B1_CAP:     next_state = len == 2'd2 ? ISSUE : B2_REQ;
            B2_REQ:     next_state = B2_CAP;
            B2_CAP:     next_state = ISSUE;
            ISSUE:      next_state = instruction_done ? OP_REQ : ISSUE;
            default:    next_state = VEC_LO_REQ;
        endcase
    end
    // Memory strobe, address and ready decode; forced low while reset is held
    always_comb begin
        mem_rd = reset_n && (state inside {VEC_LO_REQ, VEC_HI_REQ, B1_REQ, B2_REQ} || (state == OP_REQ && !halt));
        mem_addr = !reset_n             ? '0 :
                   state == VEC_LO_REQ  ? RESET_VECTOR :
                   state == VEC_HI_REQ  ? RESET_VECTOR + ADDR_WIDTH'(1) :
                   state == OP_REQ      ? pc :
                   state == B1_REQ      ? pc + ADDR_WIDTH'(1) :
                   state == B2_REQ      ? pc + ADDR_WIDTH'(2) : '0;
        instruction_ready = reset_n && state == ISSUE;
    end
    // Datapath: capture read bytes in CAP states, advance or reload PC on done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= '0;
            vec_lo         <= '0;
            len            <= '0;
            instruction_in <= '0;
            operand        <= '0;
            address_in     <= '0;
        end else begin
            case (state)
                VEC_LO_CAP: vec_lo <= mem_data;
                VEC_HI_CAP: pc <= ADDR_WIDTH'({mem_data, vec_lo});
                OP_CAP: begin
                    instruction_in <= mem_data;
                    address_in     <= pc;
                    operand        <= '0;
                    len            <= op_len(mem_data);
                end
                B1_CAP: operand[REG_WIDTH-1:0] <= mem_data;
                B2_CAP: operand[2*REG_WIDTH-1:REG_WIDTH] <= mem_data;
                ISSUE:  if (instruction_done) pc <= pc_load ? pc_load_addr : pc + ADDR_WIDTH'(len);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed tests of vector load, length decode, handshake, jump, wrap, halt and reset
module tb_fetch_sequencer;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 0;
    logic [7:0]  instruction_in;
    logic [15:0] operand;
    logic [15:0] address_in;
    logic        instruction_ready;
    logic        instruction_done = 0;
    logic        pc_load = 0;
    logic [15:0] pc_load_addr = 0;
    logic        halt = 0;
    logic [7:0]  mem [0:65535];
    int errors = 0;
    int checks = 0;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .instruction_in(instruction_in), .operand(operand), .address_in(address_in),
        .instruction_ready(instruction_ready), .instruction_done(instruction_done),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .halt(halt)
    );

    always #5 clk = ~clk;
    // Memory answers a strobe with data on the following cycle
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!instruction_ready && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic finish_instr(input logic load, input logic [15:0] addr);
        instruction_done = 1;
        pc_load = load;
        pc_load_addr = addr;
        step();
        instruction_done = 0;
        pc_load = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        step();
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd got %0b exp 0", mem_rd); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0000", mem_addr); end
        checks++; if (instruction_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", instruction_ready); end
        checks++; if ({instruction_in, operand, address_in} !== 40'h0) begin errors++; $display("FAIL rst_regs got %h %h %h exp 0", instruction_in, operand, address_in); end
        reset_n = 1;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFC) begin errors++; $display("FAIL vec_lo got rd=%0b addr=%h exp 1 FFFC", mem_rd, mem_addr); end
        step();
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL vec_lo_cap got rd=%0b exp 0", mem_rd); end
        step();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFD) begin errors++; $display("FAIL vec_hi got rd=%0b addr=%h exp 1 FFFD", mem_rd, mem_addr); end
        step();
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL vec_hi_cap got rd=%0b exp 0", mem_rd); end
        step();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h8000) begin errors++; $display("FAIL first_op got rd=%0b addr=%h exp 1 8000", mem_rd, mem_addr); end
    endtask

    task automatic test_length();
        int n;
        wait_ready(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL lda_latency got %0d exp 4", n); end
        checks++; if (instruction_in !== 8'hA9 || operand !== 16'h0042 || address_in !== 16'h8000) begin errors++; $display("FAIL lda_fields got %h %h %h exp A9 0042 8000", instruction_in, operand, address_in); end
        finish_instr(0, 0);
        checks++; if (instruction_ready !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h8002) begin errors++; $display("FAIL lda_next got rdy=%0b rd=%0b addr=%h exp 0 1 8002", instruction_ready, mem_rd, mem_addr); end
        wait_ready(n);
        checks++; if (n !== 6) begin errors++; $display("FAIL sta_latency got %0d exp 6", n); end
        checks++; if (instruction_in !== 8'h8D || operand !== 16'h0200 || address_in !== 16'h8002) begin errors++; $display("FAIL sta_fields got %h %h %h exp 8D 0200 8002", instruction_in, operand, address_in); end
        finish_instr(0, 0);
        checks++; if (mem_addr !== 16'h8005) begin errors++; $display("FAIL sta_next got %h exp 8005", mem_addr); end
        wait_ready(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL nop_latency got %0d exp 2", n); end
        checks++; if (instruction_in !== 8'hEA || operand !== 16'h0000 || address_in !== 16'h8005) begin errors++; $display("FAIL nop_fields got %h %h %h exp EA 0000 8005", instruction_in, operand, address_in); end
        finish_instr(0, 0);
        checks++; if (mem_addr !== 16'h8006) begin errors++; $display("FAIL nop_next got %h exp 8006", mem_addr); end
    endtask

    task automatic test_handshake();
        int n;
        int bad = 0;
        wait_ready(n);
        for (int i = 0; i < 10; i++) begin
            step();
            if (instruction_ready !== 1'b1 || mem_rd !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_ready got %0d bad cycles exp 0", bad); end
        finish_instr(0, 0);
        checks++; if (instruction_ready !== 1'b0) begin errors++; $display("FAIL ready_fall got %0b exp 0", instruction_ready); end
        wait_ready(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL ready_gap got %0d exp 2", n); end
    endtask

    task automatic test_jump();
        int n;
        pc_load = 1;
        pc_load_addr = 16'h5555;
        step();
        pc_load = 0;
        checks++; if (instruction_ready !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL load_no_done got rdy=%0b rd=%0b exp 1 0", instruction_ready, mem_rd); end
        finish_instr(1, 16'h1234);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h1234) begin errors++; $display("FAIL jump got rd=%0b addr=%h exp 1 1234", mem_rd, mem_addr); end
        wait_ready(n);
        finish_instr(0, 0);
        checks++; if (mem_addr !== 16'h1235) begin errors++; $display("FAIL after_jump got %h exp 1235", mem_addr); end
    endtask

    task automatic test_wrap_halt();
        int n;
        int bad = 0;
        wait_ready(n);
        finish_instr(1, 16'hFFFF);
        step();
        step();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_b1 got rd=%0b addr=%h exp 1 0000", mem_rd, mem_addr); end
        wait_ready(n);
        checks++; if (operand !== 16'h0077 || address_in !== 16'hFFFF) begin errors++; $display("FAIL wrap_fields got %h %h exp 0077 FFFF", operand, address_in); end
        finish_instr(0, 0);
        checks++; if (mem_addr !== 16'h0001) begin errors++; $display("FAIL wrap_next got %h exp 0001", mem_addr); end
        halt = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (mem_rd !== 1'b0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_rd got %0d strobes exp 0", bad); end
        halt = 0;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("FAIL halt_resume got rd=%0b addr=%h exp 1 0001", mem_rd, mem_addr); end
        wait_ready(n);
        checks++; if (n !== 2 || instruction_in !== 8'hEA || address_in !== 16'h0001) begin errors++; $display("FAIL halt_instr got n=%0d %h %h exp 2 EA 0001", n, instruction_in, address_in); end
    endtask

    task automatic test_reset_mid();
        finish_instr(0, 0);
        step();
        step();
        step();
        reset_n = 0;
        #1;
        checks++; if ({mem_rd, mem_addr, instruction_in, operand, address_in, instruction_ready} !== 58'h0) begin errors++; $display("FAIL mid_reset got rd=%0b addr=%h op=%h opd=%h adr=%h rdy=%0b exp 0", mem_rd, mem_addr, instruction_in, operand, address_in, instruction_ready); end
        step();
        reset_n = 1;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFC) begin errors++; $display("FAIL restart got rd=%0b addr=%h exp 1 FFFC", mem_rd, mem_addr); end
        step();
        step();
        step();
        step();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h8000) begin errors++; $display("FAIL restart_op got rd=%0b addr=%h exp 1 8000", mem_rd, mem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
        mem[16'h0002] = 8'hA9; mem[16'h0003] = 8'h11;
        test_reset();
        test_length();
        test_handshake();
        test_jump();
        test_wrap_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
